ball_hit_receiver: RTL and testbench
====================================

// Module: ball_hit_receiver
// PURPOSE
//  Target side of the projectile interface: consumes the spawned ball's position/flag each frame,
//  detects overlap with the opponent's hitbox, and owns opponent health, hit-stun and invulnerability.
//  Sits between the ball spawner and the opponent's movement/sprite logic; ball_hit tells the spawner to despawn.
// PARAMETERS
//  MAX_HP      9'd100  health at reset/respawn
//  DAMAGE      9'd10   health removed per hit (saturates at 0)
//  STUN_FRAMES 6'd12   frames in HIT state after a hit
//  INVULN_FRAMES 6'd30 frames in INVULN state after stun
//  TGT_W/TGT_H 10'd40/10'd60  target hitbox size from (target_x,target_y)
//  BALL_W/BALL_H 10'd16/10'd16 ball hitbox size from (ball_x,ball_y)
// PORTS
//  frame_clk     in  1   frame clock; all state updates on rising edge
//  Reset_n       in  1   synchronous, active-low reset
//  summoned_ball in  1   ball in flight
//  ball_x,ball_y in  10  ball top-left position
//  ball_face     in  1   ball direction (0 = moving +x, 1 = moving -x)
//  target_x,target_y in 10 opponent top-left position
//  ball_hit      out 1   one-frame pulse: ball struck target, spawner must despawn
//  target_health out 9   remaining health
//  hit_stun      out 1   high in HIT state (opponent input ignored)
//  invuln        out 1   high in INVULN state (sprite blink)
//  target_dead   out 1   high in DEAD state
//  knockback_dx  out 10  signed per-frame x displacement for opponent (see CONFIGURATION)
// BEHAVIOUR
//  Reset (Reset_n==0 at edge): state=IDLE, target_health=MAX_HP, counters=0, all other outputs 0; wins over all events.
//  Overlap (combinational): ball_x < target_x+TGT_W && target_x < ball_x+BALL_W && same for y;
//   all sums computed in 11 bits, no 10-bit wrap; edges touching (equal) = no overlap.
//  hit_cond = summoned_ball && overlap && !ball_consumed && state==IDLE.
//  ball_consumed: set on the frame ball_hit pulses, cleared on any frame summoned_ball==0;
//   guarantees at most one hit per ball flight even if despawn lags.
//  FSM (registered, 1-frame latency from inputs to outputs):
//   IDLE  : hit_cond -> ball_hit=1, health-=DAMAGE (sat 0); result 0 -> DEAD else -> HIT, cnt=STUN_FRAMES-1.
//   HIT   : hit_stun=1; cnt==0 -> INVULN, cnt=INVULN_FRAMES-1; else cnt--.
//   INVULN: invuln=1; cnt==0 -> IDLE; else cnt--. Overlaps here are ignored, no ball_hit.
//   DEAD  : target_dead=1; absorbing until reset; no further ball_hit.
//  ball_hit is high exactly one frame per accepted hit; not asserted when summoned_ball==0.
//  Health never underflows: DAMAGE >= health -> health=0.
//  Ball position at screen edges (x<=10 or >=590) handled as any other position.
// CONFIGURATION
//  KNOCKBACK_EN defined: in HIT, knockback_dx = +3 if latched ball_face==0, -3 if 1 (face latched at hit);
//   0 in all other states. Not defined: knockback_dx tied to 0, face latch omitted.
// STRUCTURE
//  game_pkg: hit_state_t enum {IDLE,HIT,INVULN,DEAD}; SCREEN_W=640, SCREEN_H=480; KNOCKBACK_SPEED=10'sd3.
//  Sub-module hitbox_overlap (combinational AABB, params for both box sizes) — reusable for melee later.
// TESTING
//  Ball (100,200) vs target (110,190), summoned=1 -> ball_hit 1 frame after, health 100->90, hit_stun for 12 frames.
//  Same overlap held 50 frames with summoned_ball kept 1 -> exactly one ball_hit; INVULN 30 frames then IDLE.
//  Ball at x=150, target x=110 (touching edge, TGT_W=40) -> no hit; x=149 -> hit.
//  Ten hits from MAX_HP=100 -> health 0, target_dead=1; 11th overlap -> no ball_hit, state stays DEAD.
//  Reset_n low mid-HIT -> next edge: IDLE, health 100, hit_stun 0, knockback_dx 0.
//  KNOCKBACK_EN, ball_face=1 hit -> knockback_dx=-3 for 12 frames then 0; without macro always 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types, screen constants and helpers for the projectile /
// target logic.
//   hit_state_t     : target life-cycle state (IDLE, HIT, INVULN, DEAD)
//   SCREEN_W/H      : visible playfield size in pixels
//   KNOCKBACK_SPEED : per-frame opponent displacement magnitude while stunned
//   sat_sub_hp      : health subtraction that clamps at zero
//   knockback_for   : signed displacement pushing the target along the ball's travel
//   on_screen       : true when a point lies inside the playfield
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIT    = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } hit_state_t;

  localparam logic [9:0]        SCREEN_W        = 10'd640;
  localparam logic [9:0]        SCREEN_H        = 10'd480;
  localparam logic signed [9:0] KNOCKBACK_SPEED = 10'sd3;

  // Health never wraps: a hit worth at least the remaining health empties it.
  function automatic logic [8:0] sat_sub_hp(input logic [8:0] hp, input logic [8:0] dmg);
    logic [8:0] res;
    if (dmg >= hp) begin
      res = 9'd0;
    end else begin
      res = hp - dmg;
    end
    return res;
  endfunction

  // Ball moving +x (face 0) shoves the target right, moving -x shoves it left.
  function automatic logic signed [9:0] knockback_for(input logic face);
    logic signed [9:0] res;
    if (face) begin
      res = -KNOCKBACK_SPEED;
    end else begin
      res = KNOCKBACK_SPEED;
    end
    return res;
  endfunction

  function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
    logic res;
    if ((x < SCREEN_W) && (y < SCREEN_H)) begin
      res = 1'b1;
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ball_hit_receiver_if.sv
// ball_hit_receiver_if: bundle between the ball spawner / opponent logic and
// the hit receiver.
//   master : spawner side; drives ball state and target position, reads results
//   slave  : receiver side; reads ball/target, drives hit pulse, health and status
//   summoned_ball, ball_x, ball_y, ball_face, target_x, target_y : master -> slave
//   ball_hit, target_health, hit_stun, invuln, target_dead, knockback_dx : slave -> master
interface ball_hit_receiver_if;

  logic              summoned_ball;
  logic [9:0]        ball_x;
  logic [9:0]        ball_y;
  logic              ball_face;
  logic [9:0]        target_x;
  logic [9:0]        target_y;
  logic              ball_hit;
  logic [8:0]        target_health;
  logic              hit_stun;
  logic              invuln;
  logic              target_dead;
  logic signed [9:0] knockback_dx;

  modport master (
    output summoned_ball, ball_x, ball_y, ball_face, target_x, target_y,
    input  ball_hit, target_health, hit_stun, invuln, target_dead, knockback_dx
  );

  modport slave (
    input  summoned_ball, ball_x, ball_y, ball_face, target_x, target_y,
    output ball_hit, target_health, hit_stun, invuln, target_dead, knockback_dx
  );

endinterface

// File: rtl/hitbox_overlap.sv
// hitbox_overlap: combinational axis-aligned box overlap test.
//   a_x, a_y : top-left of box A (size A_W x A_H)
//   b_x, b_y : top-left of box B (size B_W x B_H)
//   overlap  : boxes share at least one pixel; touching edges do not count
// Far edges are formed in 11 bits so boxes near x/y = 1023 never wrap.
module hitbox_overlap #(
  parameter logic [9:0] A_W = 10'd16,
  parameter logic [9:0] A_H = 10'd16,
  parameter logic [9:0] B_W = 10'd40,
  parameter logic [9:0] B_H = 10'd60
) (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       overlap
);

  logic [10:0] a_x_end_s;
  logic [10:0] a_y_end_s;
  logic [10:0] b_x_end_s;
  logic [10:0] b_y_end_s;

  assign a_x_end_s = {1'b0, a_x} + {1'b0, A_W};
  assign a_y_end_s = {1'b0, a_y} + {1'b0, A_H};
  assign b_x_end_s = {1'b0, b_x} + {1'b0, B_W};
  assign b_y_end_s = {1'b0, b_y} + {1'b0, B_H};

  // Strict comparisons on both axes: equal edges mean the boxes only touch.
  always_comb begin
    overlap = 1'b0;
    if (({1'b0, a_x} < b_x_end_s) && ({1'b0, b_x} < a_x_end_s) &&
        ({1'b0, a_y} < b_y_end_s) && ({1'b0, b_y} < a_y_end_s)) begin
      overlap = 1'b1;
    end else begin
      overlap = 1'b0;
    end
  end

endmodule

// File: rtl/ball_hit_receiver.sv
// ball_hit_receiver: target side of the projectile interface. Each frame it
// tests the flying ball against the opponent hitbox, accepts at most one hit
// per ball flight, and owns opponent health, hit-stun and invulnerability.
//   frame_clk : frame clock, all state moves on its rising edge
//   Reset_n   : synchronous active-low reset, overrides every event
//   bus       : ball_hit_receiver_if.slave (ball/target in, hit/status out)
// All outputs are registered: they reflect the inputs of the previous frame.
// Optional build macro KNOCKBACK_EN: while stunned, knockback_dx pushes the
// opponent +/-KNOCKBACK_SPEED along the ball's travel direction latched at the
// hit; without it knockback_dx is constant zero.
module ball_hit_receiver
  import game_pkg::*;
#(
  parameter logic [8:0] MAX_HP        = 9'd100,
  parameter logic [8:0] DAMAGE        = 9'd10,
  parameter logic [5:0] STUN_FRAMES   = 6'd12,
  parameter logic [5:0] INVULN_FRAMES = 6'd30,
  parameter logic [9:0] TGT_W         = 10'd40,
  parameter logic [9:0] TGT_H         = 10'd60,
  parameter logic [9:0] BALL_W        = 10'd16,
  parameter logic [9:0] BALL_H        = 10'd16
) (
  input logic                frame_clk,
  input logic                Reset_n,
  ball_hit_receiver_if.slave bus
);

  hit_state_t state_r;
  logic [5:0] cnt_r;
  logic [8:0] health_r;
  logic       consumed_r;
  logic       ball_hit_r;
  logic       hit_stun_r;
  logic       invuln_r;
  logic       dead_r;
  logic       overlap_s;
  logic       hit_cond_s;
  logic [8:0] next_hp_s;

  hitbox_overlap #(
    .A_W(BALL_W),
    .A_H(BALL_H),
    .B_W(TGT_W),
    .B_H(TGT_H)
  ) u_overlap (
    .a_x    (bus.ball_x),
    .a_y    (bus.ball_y),
    .b_x    (bus.target_x),
    .b_y    (bus.target_y),
    .overlap(overlap_s)
  );

  assign next_hp_s = sat_sub_hp(health_r, DAMAGE);

  // A hit is only accepted in IDLE and only once per flight (consumed_r).
  always_comb begin
    hit_cond_s = 1'b0;
    if (bus.summoned_ball && overlap_s && !consumed_r && (state_r == IDLE)) begin
      hit_cond_s = 1'b1;
    end else begin
      hit_cond_s = 1'b0;
    end
  end

`ifdef KNOCKBACK_EN
  logic signed [9:0] knockback_r;

  // Knockback register: loaded from the ball direction at the hit, cleared when stun ends.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      knockback_r <= 10'sd0;
    end else if ((state_r == IDLE) && hit_cond_s && (next_hp_s != 9'd0)) begin
      knockback_r <= knockback_for(bus.ball_face);
    end else if ((state_r == HIT) && (cnt_r == 6'd0)) begin
      knockback_r <= 10'sd0;
    end else begin
      knockback_r <= knockback_r;
    end
  end

  assign bus.knockback_dx = knockback_r;
`else
  logic unused_face_s;

  assign unused_face_s    = bus.ball_face;
  assign bus.knockback_dx = 10'sd0;
`endif

  // Main state machine with registered status flags.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      health_r   <= MAX_HP;
      consumed_r <= 1'b0;
      ball_hit_r <= 1'b0;
      hit_stun_r <= 1'b0;
      invuln_r   <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      ball_hit_r <= 1'b0;

      // Lock out further hits until the spawner drops this ball.
      if (!bus.summoned_ball) begin
        consumed_r <= 1'b0;
      end else if (hit_cond_s) begin
        consumed_r <= 1'b1;
      end else begin
        consumed_r <= consumed_r;
      end

      case (state_r)
        IDLE: begin
          if (hit_cond_s) begin
            ball_hit_r <= 1'b1;
            health_r   <= next_hp_s;
            if (next_hp_s == 9'd0) begin
              state_r <= DEAD;
              dead_r  <= 1'b1;
            end else begin
              state_r    <= HIT;
              cnt_r      <= STUN_FRAMES - 6'd1;
              hit_stun_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        HIT: begin
          if (cnt_r == 6'd0) begin
            state_r    <= INVULN;
            cnt_r      <= INVULN_FRAMES - 6'd1;
            hit_stun_r <= 1'b0;
            invuln_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        INVULN: begin
          if (cnt_r == 6'd0) begin
            state_r  <= IDLE;
            invuln_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        DEAD: begin
          state_r <= DEAD;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 6'd0;
          hit_stun_r <= 1'b0;
          invuln_r   <= 1'b0;
          dead_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ball_hit      = ball_hit_r;
  assign bus.target_health = health_r;
  assign bus.hit_stun      = hit_stun_r;
  assign bus.invuln        = invuln_r;
  assign bus.target_dead   = dead_r;

endmodule

// File: tb/tb_ball_hit_receiver.sv
// tb_ball_hit_receiver: randomized + directed frames against a timeline model.
// The model tracks when the last hit landed and derives stun/invuln windows
// from the frame distance to it; a monitor compares every frame's outputs.
module tb_ball_hit_receiver;

  logic frame_clk;
  logic Reset_n;

  ball_hit_receiver_if bus ();

  ball_hit_receiver dut (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic              ball_hit;
    logic [8:0]        health;
    logic              stun;
    logic              inv;
    logic              dead;
    logic signed [9:0] kb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dut_hits = 0;

  // reference model state
  int   m_f = 0;          // index of the edge the current inputs are sampled on
  int   m_lh = -1000;     // edge at which the last accepted hit landed
  int   m_health = 100;
  bit   m_dead = 1'b0;
  bit   m_consumed = 1'b0;
  bit   m_face = 1'b0;
  int   m_hits = 0;

  task automatic frame(input logic rst_n, input logic summ, input int bx, input int by,
                       input logic face, input int tx, input int ty);
    exp_t e;
    bit   hit;
    bit   ov;
    bit   idle_before;
    int   d;
    Reset_n           = rst_n;
    bus.summoned_ball = summ;
    bus.ball_x        = 10'(bx);
    bus.ball_y        = 10'(by);
    bus.ball_face     = face;
    bus.target_x      = 10'(tx);
    bus.target_y      = 10'(ty);
    hit = 1'b0;
    if (!rst_n) begin
      m_health   = 100;
      m_dead     = 1'b0;
      m_consumed = 1'b0;
      m_lh       = -1000;
    end else begin
      ov = (bx < tx + 40) && (tx < bx + 16) && (by < ty + 60) && (ty < by + 16);
      // after a hit: 12 frames stunned, 30 invulnerable, then idle again
      idle_before = !m_dead && ((m_f - 1 - m_lh) >= 42);
      hit = summ && ov && !m_consumed && idle_before;
      if (!summ) m_consumed = 1'b0;
      else if (hit) m_consumed = 1'b1;
      if (hit) begin
        m_health = (m_health <= 10) ? 0 : m_health - 10;
        if (m_health == 0) m_dead = 1'b1;
        m_lh   = m_f;
        m_face = face;
        m_hits++;
      end
    end
    d = m_f - m_lh;
    e.ball_hit = hit;
    e.health   = 9'(m_health);
    e.dead     = m_dead;
    e.stun     = !m_dead && (d >= 0) && (d <= 11);
    e.inv      = !m_dead && (d >= 12) && (d <= 41);
`ifdef KNOCKBACK_EN
    e.kb = e.stun ? (m_face ? -10'sd3 : 10'sd3) : 10'sd0;
`else
    e.kb = 10'sd0;
`endif
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    m_f++;
  endtask

  // Monitor: one comparison per frame of every registered output.
  always @(negedge frame_clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.ball_hit, bus.target_health, bus.hit_stun, bus.invuln,
           bus.target_dead, bus.knockback_dx};
      if (bus.ball_hit === 1'b1) dut_hits++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got hit=%b hp=%0d stun=%b inv=%b dead=%b kb=%0d, want hit=%b hp=%0d stun=%b inv=%b dead=%b kb=%0d",
                 $time, a.ball_hit, a.health, a.stun, a.inv, a.dead, a.kb,
                 e.ball_hit, e.health, e.stun, e.inv, e.dead, e.kb);
      end
    end
  end

  initial begin
    int tx, ty, bx, by;
    bit summ;
    // reset
    repeat (2) frame(1'b0, 1'b0, 0, 0, 1'b0, 300, 300);
    // first hit, overlap held 50 frames with the ball still summoned
    repeat (50) frame(1'b1, 1'b1, 100, 200, 1'b1, 110, 190);
    repeat (10) frame(1'b1, 1'b0, 100, 200, 1'b0, 110, 190);
    // touching edge then one pixel of overlap
    repeat (3) frame(1'b1, 1'b1, 150, 200, 1'b0, 110, 190);
    frame(1'b1, 1'b1, 149, 200, 1'b0, 110, 190);
    repeat (45) frame(1'b1, 1'b0, 149, 200, 1'b0, 110, 190);
    // drain health to zero, then one more overlap while dead
    repeat (9) begin
      frame(1'b1, 1'b1, 120, 200, 1'b0, 110, 190);
      repeat (44) frame(1'b1, 1'b0, 120, 200, 1'b0, 110, 190);
    end
    repeat (5) frame(1'b1, 1'b1, 120, 200, 1'b1, 110, 190);
    // revive, hit, reset mid-stun
    frame(1'b0, 1'b0, 0, 0, 1'b0, 110, 190);
    frame(1'b1, 1'b1, 120, 200, 1'b1, 110, 190);
    repeat (5) frame(1'b1, 1'b1, 120, 200, 1'b1, 110, 190);
    frame(1'b0, 1'b1, 120, 200, 1'b1, 110, 190);
    repeat (3) frame(1'b1, 1'b0, 120, 200, 1'b0, 110, 190);
    // screen-edge positions
    frame(1'b1, 1'b1, 0, 0, 1'b0, 0, 0);
    repeat (44) frame(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    frame(1'b1, 1'b1, 600, 400, 1'b1, 590, 380);
    repeat (44) frame(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    // randomized phase
    tx = 300; ty = 200; summ = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          tx = 0;
        end else begin
          tx = $urandom_range(0, 600);
        end
        ty = $urandom_range(0, 420);
      end
      if ($urandom_range(0, 7) == 0) summ = ~summ;
      bx = tx + $urandom_range(0, 80) - 30;
      by = ty + $urandom_range(0, 100) - 30;
      if (bx < 0) bx = 0;
      if (bx > 623) bx = 623;
      if (by < 0) by = 0;
      if (by > 463) by = 463;
      frame(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, summ, bx, by,
            1'($urandom_range(0, 1)), tx, ty);
    end
    @(negedge frame_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    checks++;
    if (dut_hits != m_hits) begin
      errors++;
      $display("FAIL hit_count: got %0d ball_hit pulses, want %0d", dut_hits, m_hits);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
